// File: rtl/carpma_birimi_pkg.sv
// Shared definitions for the multiplier: operation codes, FSM states, iteration count.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package carpma_birimi_pkg;

  // islem_i encodings (RV32M funct3[1:0] order)
  localparam logic [1:0] CARPMA_MUL    = 2'b00;
  localparam logic [1:0] CARPMA_MULH   = 2'b01;
  localparam logic [1:0] CARPMA_MULHSU = 2'b10;
  localparam logic [1:0] CARPMA_MULHU  = 2'b11;

  // Radix-4: two multiplier bits per step, 32 bits -> 16 steps
  localparam int         ADIM_SAYISI = 16;
  localparam logic [3:0] SON_ADIM    = 4'(ADIM_SAYISI - 1);

  typedef enum logic [1:0] {
    BOSTA   = 2'b00,
    HESAPLA = 2'b01,
    BITIR   = 2'b10
  } durum_t;

  // Magnitude of a 32-bit operand; -2^31 maps to 2^31, which still fits unsigned.
  function automatic logic [31:0] mutlak(input logic [31:0] x, input logic isaretli);
    if (isaretli && x[31]) return ~x + 32'd1;
    return x;
  endfunction

  // Signedness class stored with a cached product. MUL only needs the low word,
  // which is identical for every class, so it is computed (and filed) as unsigned.
  function automatic logic [1:0] isaret_sinifi(input logic [1:0] islem);
    return (islem == CARPMA_MUL) ? CARPMA_MULHU : islem;
  endfunction

endpackage

// File: rtl/carpma_birimi_adim.sv
// One radix-4 shift-add step: acc_hi + |rs1| * b[1:0], result split into new acc_hi and the two bits shifted out.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the step result is registered.
// Ports: acc_hi (34 b running high part), b_ikili (two multiplier bits), a (|rs1|), a3 (3*|rs1|),
//        acc_yeni (sum >> 2), dusen (sum[1:0], shifted into the top of the multiplier register).
module carpma_birimi_adim (
  input  logic [33:0] acc_hi,
  input  logic [1:0]  b_ikili,
  input  logic [31:0] a,
  input  logic [33:0] a3,
  output logic [33:0] acc_yeni,
  output logic [1:0]  dusen
);

  logic [33:0] ek;
  logic [33:0] toplam;

  always_comb begin
    ek = '0;
    case (b_ikili)
      2'd0: ek = '0;
      2'd1: ek = {2'b00, a};
      2'd2: ek = {1'b0, a, 1'b0};
      2'd3: ek = a3;
      default: ek = '0;
    endcase
  end

  // acc_hi entering a step is < 2^32 (it was shifted right by two), and the
  // addend is at most 3*(2^32-1), so the sum always fits in 34 bits.
  assign toplam   = acc_hi + ek;
  assign acc_yeni = {2'b00, toplam[33:2]};
  assign dusen    = toplam[1:0];

endmodule

// File: rtl/carpma_birimi.sv
// Multi-cycle 32x32 RV32M multiplier (MUL/MULH/MULHSU/MULHU), radix-4 shift-add on magnitudes, sign fixed at the end.
// Latency: request seen in cycle 0 -> bitti_o=1 with sonuc_o in cycle 17 (cycle 1 on a result-cache hit).
// Backpressure: requester holds basla_i until bitti_o=1; dropping basla_i aborts, bitti_o=1 immediately.
// Ports: clk_i, rst_ni (async active-low), basla_i (request), islem_i (op, sampled in BOSTA),
//        carpilan_i (rs1), carpan_i (rs2), sonuc_o (result, non-zero only in BITIR), bitti_o (idle/done).
// Build option: define CARPMA_ONBELLEK_EN for a one-entry result cache that skips recomputation
//               on repeated operands (e.g. MULH followed by MUL).
module carpma_birimi
  import carpma_birimi_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        basla_i,
  input  logic [1:0]  islem_i,
  input  logic [31:0] carpilan_i,
  input  logic [31:0] carpan_i,
  output logic [31:0] sonuc_o,
  output logic        bitti_o
);

  durum_t      durum_q, durum_d;

  logic [31:0] a_q;        // |rs1|
  logic [33:0] a3_q;       // 3*|rs1|, precomputed so each step needs one adder
  logic [33:0] acc_q;      // running high part of the product
  logic [31:0] b_q;        // |rs2|, shifted right; fills with low product bits
  logic [3:0]  sayac_q;
  logic        neg_q;
  logic [1:0]  islem_q;

  logic        isaretli1, isaretli2;
  logic [31:0] a_mut, b_mut;
  logic [33:0] a3_mut;
  logic        neg_yeni;
  logic        baslat;

  logic [33:0] acc_yeni;
  logic [1:0]  dusen;

  logic [63:0] mutlak_carpim;
  logic [63:0] hesap_carpim;
  logic [63:0] carpim;
  logic        isabet;

  // ---------------------------------------------------------------------------
  // Operand conditioning (only used in the BOSTA cycle that accepts a request)
  // ---------------------------------------------------------------------------
  always_comb begin
    isaretli1 = (islem_i == CARPMA_MULH) || (islem_i == CARPMA_MULHSU);
    isaretli2 = (islem_i == CARPMA_MULH);
    a_mut     = mutlak(carpilan_i, isaretli1);
    b_mut     = mutlak(carpan_i, isaretli2);
    a3_mut    = {2'b00, a_mut} + {1'b0, a_mut, 1'b0};
    neg_yeni  = (isaretli1 & carpilan_i[31]) ^ (isaretli2 & carpan_i[31]);
  end

  assign baslat = (durum_q == BOSTA) && basla_i;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) durum_q <= BOSTA;
    else         durum_q <= durum_d;
  end

  always_comb begin
    durum_d = durum_q;
    case (durum_q)
      BOSTA: begin
        if (basla_i) durum_d = isabet ? BITIR : HESAPLA;
      end
      HESAPLA: begin
        if (!basla_i)                durum_d = BOSTA;
        else if (sayac_q == SON_ADIM) durum_d = BITIR;
      end
      BITIR:   durum_d = BOSTA;
      default: durum_d = BOSTA;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  carpma_birimi_adim u_adim (
    .acc_hi   (acc_q),
    .b_ikili  (b_q[1:0]),
    .a        (a_q),
    .a3       (a3_q),
    .acc_yeni (acc_yeni),
    .dusen    (dusen)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q     <= '0;
      a3_q    <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      sayac_q <= '0;
      neg_q   <= 1'b0;
      islem_q <= CARPMA_MUL;
    end else if (baslat) begin
      a_q     <= a_mut;
      a3_q    <= a3_mut;
      acc_q   <= '0;
      b_q     <= b_mut;
      sayac_q <= '0;
      neg_q   <= neg_yeni;
      islem_q <= islem_i;
    end else if ((durum_q == HESAPLA) && basla_i) begin
      acc_q   <= acc_yeni;
      b_q     <= {dusen, b_q[31:2]};
      sayac_q <= sayac_q + 4'd1;
    end
  end

  // After 16 steps the low word has fully migrated into b_q.
  assign mutlak_carpim = {acc_q[31:0], b_q};
  assign hesap_carpim  = neg_q ? (~mutlak_carpim + 64'd1) : mutlak_carpim;

  // ---------------------------------------------------------------------------
  // Optional one-entry result cache
  // ---------------------------------------------------------------------------
`ifdef CARPMA_ONBELLEK_EN
  logic        onb_gecerli_q;
  logic [31:0] onb_rs1_q, onb_rs2_q;
  logic [1:0]  onb_sinif_q;
  logic [63:0] onb_carpim_q;
  logic        isabet_q;
  logic [31:0] rs1_q, rs2_q;   // raw operands of the op in flight, for the cache tag

  // MUL only needs the low word, which any signedness class provides.
  assign isabet = onb_gecerli_q && (onb_rs1_q == carpilan_i) && (onb_rs2_q == carpan_i) &&
                  ((islem_i == CARPMA_MUL) || (islem_i == onb_sinif_q));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      onb_gecerli_q <= 1'b0;
      onb_rs1_q     <= '0;
      onb_rs2_q     <= '0;
      onb_sinif_q   <= CARPMA_MUL;
      onb_carpim_q  <= '0;
      isabet_q      <= 1'b0;
      rs1_q         <= '0;
      rs2_q         <= '0;
    end else begin
      if (baslat) begin
        isabet_q <= isabet;
        rs1_q    <= carpilan_i;
        rs2_q    <= carpan_i;
      end
      // Only freshly computed products are filed; an aborted op never reaches BITIR.
      if ((durum_q == BITIR) && !isabet_q) begin
        onb_gecerli_q <= 1'b1;
        onb_rs1_q     <= rs1_q;
        onb_rs2_q     <= rs2_q;
        onb_sinif_q   <= isaret_sinifi(islem_q);
        onb_carpim_q  <= hesap_carpim;
      end
    end
  end

  assign carpim = isabet_q ? onb_carpim_q : hesap_carpim;
`else
  assign isabet = 1'b0;
  assign carpim = hesap_carpim;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    sonuc_o = '0;
    if ((durum_q == BITIR) && basla_i)
      sonuc_o = (islem_q == CARPMA_MUL) ? carpim[31:0] : carpim[63:32];
  end

  assign bitti_o = !basla_i || (durum_q == BITIR);

endmodule

// File: tb/tb_carpma_birimi.sv
// Self-checking bench for carpma_birimi: directed corners plus randomized ops against a 64-bit arithmetic model.
// Latency: expects 17 cycles per computed op, 1 cycle on a modelled cache hit (CARPMA_ONBELLEK_EN).
// Backpressure: holds basla_i until bitti_o, exercises abort, async reset and back-to-back requests.
module tb_carpma_birimi;
  import carpma_birimi_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        basla_i = 1'b0;
  logic [1:0]  islem_i = 2'b00;
  logic [31:0] carpilan_i = '0;
  logic [31:0] carpan_i = '0;
  logic [31:0] sonuc_o;
  logic        bitti_o;

  int n_test = 0;
  int n_fail = 0;

  // Model of the result cache contents (only consulted when the cache is built in)
  bit          m_gecerli = 1'b0;
  logic [31:0] m_rs1 = '0, m_rs2 = '0;
  logic [1:0]  m_sinif = 2'b00;

  carpma_birimi dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .basla_i    (basla_i),
    .islem_i    (islem_i),
    .carpilan_i (carpilan_i),
    .carpan_i   (carpan_i),
    .sonuc_o    (sonuc_o),
    .bitti_o    (bitti_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: extend each operand to 64 bits per RV32M signedness and multiply.
  function automatic logic [31:0] beklenen(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] x, y, p;
    x = (op == CARPMA_MULH || op == CARPMA_MULHSU) ? {{32{a[31]}}, a} : {32'd0, a};
    y = (op == CARPMA_MULH) ? {{32{b[31]}}, b} : {32'd0, b};
    p = x * y;
    return (op == CARPMA_MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic bit model_isabet(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef CARPMA_ONBELLEK_EN
    return m_gecerli && (m_rs1 == a) && (m_rs2 == b) &&
           ((op == CARPMA_MUL) || (op == m_sinif));
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_kaydet(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    m_gecerli = 1'b1;
    m_rs1     = a;
    m_rs2     = b;
    m_sinif   = (op == CARPMA_MUL) ? CARPMA_MULHU : op;
  endtask

  // Issue one request and check busy flag, latency and result.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit tut, input bit karistir, input string ad);
    logic [31:0] exp;
    int          exp_lat;
    int          cyc;
    bit          hit;
    exp     = beklenen(op, a, b);
    hit     = model_isabet(op, a, b);
    exp_lat = hit ? 1 : 17;
    @(posedge clk_i); #1;
    basla_i = 1'b1; islem_i = op; carpilan_i = a; carpan_i = b;
    #1;
    n_test++;
    if (bitti_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_c0: bitti_o=%b want 0", ad, bitti_o);
    end
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk_i); #1;
      cyc++;
      if (bitti_o === 1'b1) break;
      if (karistir) begin
        islem_i = 2'($urandom); carpilan_i = $urandom; carpan_i = $urandom;
      end
    end
    n_test++;
    if (cyc != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", ad, cyc, exp_lat);
    end
    n_test++;
    if (sonuc_o !== exp) begin
      n_fail++;
      $display("FAIL %s result: op=%0d a=%h b=%h got %h want %h", ad, op, a, b, sonuc_o, exp);
    end
    if (!hit) model_kaydet(op, a, b);
    if (!tut) basla_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; basla_i = 1'b0;
    #3;
    n_test++;
    if (bitti_o !== 1'b1) begin n_fail++; $display("FAIL reset_bitti: got %b want 1", bitti_o); end
    n_test++;
    if (sonuc_o !== 32'd0) begin n_fail++; $display("FAIL reset_sonuc: got %h want 0", sonuc_o); end
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    m_gecerli = 1'b0;
    @(posedge clk_i); #1;
    n_test++;
    if (bitti_o !== 1'b1 || sonuc_o !== 32'd0) begin
      n_fail++; $display("FAIL idle_after_reset: bitti=%b sonuc=%h want 1/0", bitti_o, sonuc_o);
    end
  endtask

  task automatic test_mul_basic();
    run_op(CARPMA_MUL, 32'd7, 32'd6, 1'b0, 1'b0, "mul_7x6");
  endtask

  task automatic test_corners();
    run_op(CARPMA_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "mulh_m1xm1");
    run_op(CARPMA_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "mulhu_ffxff");
    run_op(CARPMA_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "mul_ffxff");
    run_op(CARPMA_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "mulhsu_min");
    run_op(CARPMA_MULH,   32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, "mulh_minxmin");
    run_op(CARPMA_MULH,   32'd0, 32'h8765_4321, 1'b0, 1'b0, "mulh_0xb");
    run_op(CARPMA_MULHU,  32'h8765_4321, 32'd0, 1'b0, 1'b0, "mulhu_ax0");
  endtask

  task automatic test_abort();
    @(posedge clk_i); #1;
    basla_i = 1'b1; islem_i = CARPMA_MUL; carpilan_i = 32'd3; carpan_i = 32'd5;
    repeat (5) begin @(posedge clk_i); #1; end
    n_test++;
    if (bitti_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", bitti_o); end
    basla_i = 1'b0;
    #1;
    n_test++;
    if (bitti_o !== 1'b1 || sonuc_o !== 32'd0) begin
      n_fail++; $display("FAIL abort_drop: bitti=%b sonuc=%h want 1/0", bitti_o, sonuc_o);
    end
    run_op(CARPMA_MUL, 32'd3, 32'd5, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_cache();
    run_op(CARPMA_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, "cache_mulhu");
    run_op(CARPMA_MUL,   32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, "cache_mul");
    run_op(CARPMA_MULH,  32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, "cache_mulh");
    run_op(CARPMA_MUL,   32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, "b2b_mul");
    run_op(CARPMA_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, "b2b_mulhu");
  endtask

  task automatic test_async_reset();
    int cyc;
    @(posedge clk_i); #1;
    basla_i = 1'b1; islem_i = CARPMA_MUL; carpilan_i = 32'd9; carpan_i = 32'd11;
    repeat (9) begin @(posedge clk_i); #1; end
    #2 rst_ni = 1'b0;
    #1;
    n_test++;
    if (sonuc_o !== 32'd0) begin n_fail++; $display("FAIL areset_sonuc: got %h want 0", sonuc_o); end
    m_gecerli = 1'b0;
    #2 rst_ni = 1'b1;
    // The state was cleared without a clock edge, so this cycle restarts the request.
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk_i); #1;
      cyc++;
      if (bitti_o === 1'b1) break;
    end
    n_test++;
    if (cyc != 17) begin n_fail++; $display("FAIL areset_restart_latency: got %0d want 17", cyc); end
    n_test++;
    if (sonuc_o !== 32'd99) begin n_fail++; $display("FAIL areset_restart_result: got %h want 63", sonuc_o); end
    model_kaydet(CARPMA_MUL, 32'd9, 32'd11);
    basla_i = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] kenar [5];
    logic [31:0] a, b, pa, pb;
    logic [1:0]  op;
    int          secim;
    kenar[0] = 32'h0; kenar[1] = 32'h1; kenar[2] = 32'hFFFF_FFFF;
    kenar[3] = 32'h8000_0000; kenar[4] = 32'h7FFF_FFFF;
    pa = 32'd1; pb = 32'd1;
    for (int i = 0; i < 40; i++) begin
      op    = 2'($urandom_range(0, 3));
      secim = $urandom_range(0, 5);
      if (secim == 0) begin
        a = pa; b = pb;
      end else if (secim == 1) begin
        a = kenar[$urandom_range(0, 4)]; b = kenar[$urandom_range(0, 4)];
      end else begin
        a = $urandom; b = $urandom;
      end
      run_op(op, a, b, ($urandom_range(0, 3) == 0), 1'b1, "random");
      pa = a; pb = b;
    end
    @(posedge clk_i); #1;
    basla_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_corners();
    test_abort();
    test_cache();
    test_async_reset();
    test_random();
    repeat (2) @(posedge clk_i);
    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule
